axis_wide_uart: RTL and testbench

//   Parametrised AXI-Stream <-> UART bridge. Serialises one DATA_W-bit word into DATA_W/8 UART

---
 rtl/axis_wide_uart_pkg.sv | 14 +
 rtl/axis_wide_uart_fifo.sv | 41 ++++
 rtl/axis_wide_uart.sv | 214 +++++++++++++++++++++
 tb/tb_axis_wide_uart.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_wide_uart_pkg.sv
// axis_wide_uart_pkg: shared FSM state types, frame length and counter-width helper.
// AXIS_WIDE_UART_PARITY_EN adds an even-parity bit to every frame (11 bits instead of 10).
package axis_wide_uart_pkg;
`ifdef AXIS_WIDE_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_wide_uart_fifo.sv
// axis_wide_uart_fifo: synchronous word FIFO, pop takes effect before push so a full FIFO accepts push+pop.
// Ports: clk, rst (async, active-high), i_push/i_data write side, i_pop read request,
//        o_data head word (0 when empty), o_valid non-empty, o_full.
module axis_wide_uart_fifo
  import axis_wide_uart_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);
  localparam int AW = cw(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign o_valid = r_cnt != '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!o_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/axis_wide_uart.sv
// axis_wide_uart: AXI-Stream word <-> UART byte-stream bridge with RX word FIFO and error reporting.
// Ports: clk, rst (async, active-high); s_axis_* word to transmit; m_axis_* received word;
//        RsRx/RsTx serial pins; rx_frame_err/rx_parity_err 1-cycle pulses; rx_overflow sticky.
// AXIS_WIDE_UART_PARITY_EN enables even parity per byte; otherwise 8N1 and rx_parity_err is 0.
module axis_wide_uart
  import axis_wide_uart_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              RsRx,
  output logic              RsTx,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overflow
);
  localparam int NB = DATA_W / 8;
  localparam int CW = cw(CLKS_PER_BIT);
  localparam int BW = cw(NB);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_EARLY = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] C_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(NB - 1);

  tx_state_t r_tx_st;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [BW-1:0] r_tx_byte;
  logic [DATA_W-1:0] r_tx_sh;
  logic r_tx_par;
  logic w_tx_tick;
  assign w_tx_tick = r_tx_cnt == C_LAST;

  // The last stop bit hands over to TX_IDLE one cycle early so a waiting word is
  // accepted exactly as that stop bit ends: consecutive words leave no idle gap.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_st       <= TX_IDLE;
      RsTx          <= 1'b1;
      s_axis_tready <= 1'b0;
      r_tx_cnt      <= '0;
      r_tx_bit      <= '0;
      r_tx_byte     <= '0;
      r_tx_sh       <= '0;
      r_tx_par      <= 1'b0;
    end else begin
      r_tx_cnt <= (r_tx_st == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
      case (r_tx_st)
        TX_IDLE:
          if (s_axis_tready && s_axis_tvalid) begin
            r_tx_st       <= TX_START;
            RsTx          <= 1'b0;
            s_axis_tready <= 1'b0;
            r_tx_sh       <= s_axis_tdata;
            r_tx_byte     <= '0;
          end else s_axis_tready <= 1'b1;
        TX_START:
          if (w_tx_tick) begin
            r_tx_st  <= TX_DATA;
            RsTx     <= r_tx_sh[0];
            r_tx_par <= r_tx_sh[0];
            r_tx_sh  <= r_tx_sh >> 1;
            r_tx_bit <= '0;
          end
        TX_DATA:
          if (w_tx_tick) begin
            if (r_tx_bit == 3'd7) begin
`ifdef AXIS_WIDE_UART_PARITY_EN
              r_tx_st <= TX_PARITY;
              RsTx    <= r_tx_par;
`else
              r_tx_st <= TX_STOP;
              RsTx    <= 1'b1;
`endif
            end else begin
              RsTx     <= r_tx_sh[0];
              r_tx_par <= r_tx_par ^ r_tx_sh[0];
              r_tx_sh  <= r_tx_sh >> 1;
              r_tx_bit <= r_tx_bit + 3'd1;
            end
          end
`ifdef AXIS_WIDE_UART_PARITY_EN
        TX_PARITY:
          if (w_tx_tick) begin
            r_tx_st <= TX_STOP;
            RsTx    <= 1'b1;
          end
`endif
        TX_STOP:
          if (r_tx_byte == B_LAST && r_tx_cnt == C_EARLY) begin
            r_tx_st       <= TX_IDLE;
            s_axis_tready <= 1'b1;
          end else if (w_tx_tick) begin
            r_tx_st   <= TX_START;
            RsTx      <= 1'b0;
            r_tx_byte <= r_tx_byte + BW'(1);
          end
        default: r_tx_st <= TX_IDLE;
      endcase
    end

  rx_state_t r_rx_st;
  logic r_rx_s1, r_rx_s2, r_rx_d;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [BW-1:0] r_rx_idx;
  logic [7:0] r_rx_byte;
  logic [DATA_W-1:0] r_rx_word;
  logic r_rx_bad;
  logic w_rx_tick, w_push, w_full;
  logic [DATA_W+7:0] w_rx_cat;
  logic [DATA_W-1:0] w_rx_next;
  assign w_rx_tick = r_rx_cnt == C_LAST;
  assign w_push    = r_rx_st == RX_STOP && w_rx_tick && r_rx_s2 && !r_rx_bad && r_rx_idx == B_LAST;
  // Bytes shift in from the top, so after NB bytes the first one sits in [7:0].
  assign w_rx_cat  = {r_rx_byte, r_rx_word};
  assign w_rx_next = w_rx_cat[DATA_W+7:8];

`ifndef AXIS_WIDE_UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_d       <= 1'b1;
      r_rx_st      <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_idx     <= '0;
      r_rx_byte    <= '0;
      r_rx_word    <= '0;
      r_rx_bad     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
`ifdef AXIS_WIDE_UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_s1      <= RsRx;
      r_rx_s2      <= r_rx_s1;
      r_rx_d       <= r_rx_s2;
      rx_frame_err <= 1'b0;
`ifdef AXIS_WIDE_UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      r_rx_cnt <= (r_rx_st == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      if (w_push && w_full && !m_axis_tready) rx_overflow <= 1'b1;
      case (r_rx_st)
        RX_IDLE: if (r_rx_d && !r_rx_s2) r_rx_st <= RX_START;
        RX_START:
          if (r_rx_cnt == C_HALF) begin
            r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_bad <= 1'b0;
          end
        RX_DATA:
          if (w_rx_tick) begin
            r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
            r_rx_bit  <= r_rx_bit + 3'd1;
`ifdef AXIS_WIDE_UART_PARITY_EN
            if (r_rx_bit == 3'd7) r_rx_st <= RX_PARITY;
`else
            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
`endif
          end
`ifdef AXIS_WIDE_UART_PARITY_EN
        RX_PARITY:
          if (w_rx_tick) begin
            r_rx_st <= RX_STOP;
            if (r_rx_s2 != ^r_rx_byte) begin
              r_rx_bad      <= 1'b1;
              rx_parity_err <= 1'b1;
              r_rx_idx      <= '0;
            end
          end
`endif
        RX_STOP:
          if (w_rx_tick) begin
            r_rx_st <= RX_IDLE;
            if (!r_rx_s2) begin
              rx_frame_err <= 1'b1;
              r_rx_idx     <= '0;
            end else if (!r_rx_bad) begin
              r_rx_word <= w_rx_next;
              r_rx_idx  <= (r_rx_idx == B_LAST) ? '0 : r_rx_idx + BW'(1);
            end
          end
        default: r_rx_st <= RX_IDLE;
      endcase
    end

  axis_wide_uart_fifo #(.W(DATA_W), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_rx_next),
    .i_pop  (m_axis_tready),
    .o_data (m_axis_tdata),
    .o_valid(m_axis_tvalid),
    .o_full (w_full)
  );
endmodule

// File: tb/tb_axis_wide_uart.sv
// tb_axis_wide_uart: scoreboard bench for axis_wide_uart (64-bit/depth-2 main DUT, 32-bit TX-timing DUT).
module tb_axis_wide_uart;
  localparam int CPB = 4;
`ifdef AXIS_WIDE_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int T64 = 8 * FB * CPB;
  localparam int T32 = 4 * FB * CPB;

  logic clk = 0, rst = 1;
  logic [63:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 0, s_tready, m_tvalid, m_tready = 1;
  logic tx, fe, pe, ovf;
  logic r_drive = 0, r_line = 1;
  logic [31:0] s32_tdata = '0, m32_tdata;
  logic s32_tvalid = 0, s32_tready, m32_tvalid, tx32, fe32, pe32, ovf32;
  logic w_rx;
  assign w_rx = r_drive ? r_line : tx;

  int n_checks = 0, n_fail = 0, n_fe = 0, n_pe = 0, cyc = 0;
  logic [63:0] q[$];
  int acc32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  axis_wide_uart #(.DATA_W(64), .CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .RsRx(w_rx), .RsTx(tx), .rx_frame_err(fe), .rx_parity_err(pe), .rx_overflow(ovf));

  axis_wide_uart #(.DATA_W(32), .CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) u_dut32 (
    .clk(clk), .rst(rst), .s_axis_tdata(s32_tdata), .s_axis_tvalid(s32_tvalid), .s_axis_tready(s32_tready),
    .m_axis_tdata(m32_tdata), .m_axis_tvalid(m32_tvalid), .m_axis_tready(1'b1),
    .RsRx(tx32), .RsTx(tx32), .rx_frame_err(fe32), .rx_parity_err(pe32), .rx_overflow(ovf32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (q.size() == 0) check("unexpected_beat", m_tdata, 64'hx);
      else check("rx_word", m_tdata, q.pop_front());
    end
    if (fe) n_fe++;
    if (pe) n_pe++;
    if (!rst && s32_tvalid && s32_tready) acc32.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input bit exp);
    bit ok = 0;
    s_tdata = d;
    s_tvalid = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (s_tready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    tick(1);
    if (exp) q.push_back(d);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && q.size() > 0; i++) @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic par, input logic stop);
    r_line = 0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      r_line = b[i];
      tick(CPB);
    end
`ifdef AXIS_WIDE_UART_PARITY_EN
    r_line = par;
    tick(CPB);
`endif
    r_line = stop;
    tick(CPB);
    r_line = 1;
  endtask

  task automatic decode32(output logic [7:0] b, output logic stop);
    b = '0;
    stop = 0;
    for (int i = 0; i < 500 && tx32; i++) @(negedge clk);
    check("tx32_start_seen", 64'(tx32), 64'd0);
    repeat (CPB + CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b[i] = tx32;
      repeat (CPB) @(negedge clk);
    end
    if (FB == 11) repeat (CPB) @(negedge clk);
    stop = tx32;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    logic [7:0] b;
    logic st;
    int fe0;
    tick(3);
    @(negedge clk);
    check("rst_rstx", 64'(tx), 64'd1);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    check("rst_mdata", m_tdata, 64'd0);
    check("rst_errs", {61'd0, fe, pe, ovf}, 64'd0);
    tick(1);
    rst = 0;
    check("tready_at_release", 64'(s_tready), 64'd0);
    tick(1);
    check("tready_after_rst", 64'(s_tready), 64'd1);

    send(64'hfeedfacedeadbeef, 1);
    s_tvalid = 0;
    drain(T64 + 100);
    check("t1_no_frame_err", 64'(n_fe), 64'd0);
    check("t1_no_parity_err", 64'(n_pe), 64'd0);
    check("t1_mvalid_idle", 64'(m_tvalid), 64'd0);

    fork
      begin
        s32_tdata = 32'h11223344;
        s32_tvalid = 1;
        for (int i = 0; i < 1000 && !(s32_tready && s32_tdata == 32'h11223344); i++) @(negedge clk);
        tick(1);
        s32_tdata = 32'h55667788;
        for (int i = 0; i < 1000 && !s32_tready; i++) @(negedge clk);
        tick(1);
        s32_tvalid = 0;
      end
      decode32(b, st);
    join
    check("t2_first_byte", 64'(b), 64'h44);
    check("t2_stop_bit", 64'(st), 64'd1);
    check("t2_accepts", 64'(acc32.size()), 64'd2);
    if (acc32.size() == 2) check("t2_word_period", 64'(acc32[1] - acc32[0]), 64'(T32));

    m_tready = 0;
    send(64'h0102030405060708, 1);
    send(64'h1112131415161718, 1);
    send(64'h2122232425262728, 0);
    s_tvalid = 0;
    tick(T64 + 40);
    check("t3_overflow", 64'(ovf), 64'd1);
    check("t3_mvalid_held", 64'(m_tvalid), 64'd1);
    check("t3_head_stable", m_tdata, 64'h0102030405060708);
    m_tready = 1;
    drain(50);
    tick(2);
    check("t3_fifo_empty", 64'(m_tvalid), 64'd0);

    r_drive = 1;
    fe0 = n_fe;
    rx_byte(8'hA5, ^8'hA5, 0);
    tick(2 * CPB);
    check("t4_frame_err_pulse", 64'(n_fe - fe0), 64'd1);
    check("t4_no_beat", 64'(m_tvalid), 64'd0);
    w = 64'h0123456789abcdef;
    q.push_back(w);
    for (int i = 0; i < 8; i++) rx_byte(w[8*i +: 8], ^w[8*i +: 8], 1);
    drain(100);
    check("t4_no_more_frame_err", 64'(n_fe - fe0), 64'd1);

`ifdef AXIS_WIDE_UART_PARITY_EN
    w = 64'h8899aabbccddeeff;
    for (int i = 0; i < 7; i++) rx_byte(w[8*i +: 8], ^w[8*i +: 8], 1);
    rx_byte(8'h01, 1'b0, 1);
    tick(2 * CPB);
    check("t6_parity_err_pulse", 64'(n_pe), 64'd1);
    check("t6_no_beat", 64'(m_tvalid), 64'd0);
    w = 64'h5a5a0f0ff0f0a5a5;
    q.push_back(w);
    for (int i = 0; i < 8; i++) rx_byte(w[8*i +: 8], ^w[8*i +: 8], 1);
    drain(100);
`else
    check("t6_parity_err_tied", 64'(n_pe), 64'd0);
`endif
    r_drive = 0;

    m_tready = 0;
    send(64'hcafef00d12345678, 0);
    s_tvalid = 0;
    for (int i = 0; i < T64 + 100 && !m_tvalid; i++) @(negedge clk);
    check("t5_word_buffered", 64'(m_tvalid), 64'd1);
    send(64'h7766554433221100, 0);
    s_tvalid = 0;
    tick(CPB * 5);
    @(posedge clk);
    #3 rst = 1;
    #1;
    check("t5_async_rstx", 64'(tx), 64'd1);
    check("t5_async_mvalid", 64'(m_tvalid), 64'd0);
    check("t5_async_mdata", m_tdata, 64'd0);
    q.delete();
    tick(2);
    rst = 0;
    check("t5_overflow_cleared", 64'(ovf), 64'd0);
    m_tready = 1;
    send(64'h0f1e2d3c4b5a6978, 1);
    s_tvalid = 0;
    drain(T64 + 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
